regfile_bypass: RTL

- 32 x 64-bit ARMv8 general-purpose register file for the ID stage of the pipelined CPU.
- One synchronous write port is driven by the WB stage. Two asynchronous read ports feed the ID/EX pipeline register and the forwarding muxes.
- Includes internal write-to-read bypass, so an instruction in ID sees the value WB is writing in the same cycle.
- X31 (XZR) always reads as zero.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_read_mux.sv | 40 ++++
 rtl/regfile_bypass.sv | 73 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the ID-stage register file.
// Also provides the 4:1 cell used to build the read-port mux trees.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;
   localparam int DEPTH    = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   function automatic word_t mux4(input word_t a, input word_t b,
                                  input word_t c, input word_t d,
                                  input logic [1:0] sel);
      word_t result;
      case (sel)
         2'd0:    result = a;
         2'd1:    result = b;
         2'd2:    result = c;
         default: result = d;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One stateless 32:1 read port: 4:1 tree, 4:1 tree, final 2:1,
// then the outer XZR / write-bypass override.
module regfile_read_mux
   import regfile_pkg::*;
(
   input  reg_idx_t            i_sel,
   input  word_t [DEPTH-1:0]   i_words,
   input  logic                i_bypass,
   input  word_t               i_bypassData,
   output word_t               o_data
);

   word_t [7:0] w_level1;
   word_t [1:0] w_level2;
   word_t       w_treeOut;

   always_comb begin
      for (int g = 0; g < 8; g++) begin
         w_level1[g] = mux4(i_words[4*g], i_words[4*g+1],
                            i_words[4*g+2], i_words[4*g+3], i_sel[1:0]);
      end
      for (int g = 0; g < 2; g++) begin
         w_level2[g] = mux4(w_level1[4*g], w_level1[4*g+1],
                            w_level1[4*g+2], w_level1[4*g+3], i_sel[3:2]);
      end
      w_treeOut = i_sel[4] ? w_level2[1] : w_level2[0];
   end

   // XZR takes priority over bypass so a write aimed at X31 can never leak out.
   always_comb begin
      if (i_sel == reg_idx_t'(ZERO_REG)) begin
         o_data = '0;
      end else if (i_bypass) begin
         o_data = i_bypassData;
      end else begin
         o_data = w_treeOut;
      end
   end

endmodule

// File: rtl/regfile_bypass.sv
// 32 x 64 ARMv8 register file with one WB write port, two async read
// ports, write-first bypass and a hardwired-zero X31.
module regfile_bypass
   import regfile_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     RegWrite,
   input  reg_idx_t WriteRegister,
   input  word_t    WriteData,
   input  reg_idx_t ReadRegister1,
   input  reg_idx_t ReadRegister2,
   output word_t    ReadData1,
   output word_t    ReadData2
);

   word_t              r_mem [ZERO_REG];
   logic [ZERO_REG-1:0] w_writeEn;
   word_t [DEPTH-1:0]   w_words;
   logic               w_writeValid;
   logic               w_bypass1;
   logic               w_bypass2;

   // Decoder output for X31 is never built: there is no storage behind it.
   always_comb begin
      for (int i = 0; i < ZERO_REG; i++) begin
         w_writeEn[i] = RegWrite && (WriteRegister == reg_idx_t'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ZERO_REG; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ZERO_REG; i++) begin
            if (w_writeEn[i]) begin
               r_mem[i] <= WriteData;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < ZERO_REG; i++) begin
         w_words[i] = r_mem[i];
      end
      w_words[ZERO_REG] = '0;
   end

   // Bypass is suppressed during reset because that cycle's write is dropped.
   assign w_writeValid = reset_n && RegWrite && (WriteRegister != reg_idx_t'(ZERO_REG));
   assign w_bypass1    = w_writeValid && (WriteRegister == ReadRegister1);
   assign w_bypass2    = w_writeValid && (WriteRegister == ReadRegister2);

   regfile_read_mux u_readMux1 (
      .i_sel        (ReadRegister1),
      .i_words      (w_words),
      .i_bypass     (w_bypass1),
      .i_bypassData (WriteData),
      .o_data       (ReadData1)
   );

   regfile_read_mux u_readMux2 (
      .i_sel        (ReadRegister2),
      .i_words      (w_words),
      .i_bypass     (w_bypass2),
      .i_bypassData (WriteData),
      .o_data       (ReadData2)
   );

endmodule
